// File: rtl/warmup_sequencer.sv
// Bubble-memory heater warm-up sequencer: drives the elapsed-seconds counter
// strobes and reports READY or FAIL from its readings.
module warmup_sequencer #(
    parameter logic [15:0] MIN_WARMUP  = 16'd30,
    parameter logic [15:0] MAX_WARMUP  = 16'd600,
    parameter logic [15:0] STABLE_TIME = 16'd5
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        WARMUP_REQ,
    input  logic        TEMP_OK,
    output logic        TIMER_nSTART,
    output logic        TIMER_nRESET,
    input  logic [15:0] TIMER_ELAPSED,
    input  logic        TIMER_OVFL,
    output logic        HEATER_EN,
    output logic        BUBBLE_READY,
    output logic        WARMUP_FAIL,
    output logic [2:0]  STATE
);

    localparam int unsigned TIME_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_HEAT   = 3'd2;
    localparam logic [2:0] ST_STABLE = 3'd3;
    localparam logic [2:0] ST_READY  = 3'd4;
    localparam logic [2:0] ST_FAIL   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [TIME_W-1:0] snap_q, snap_d;
    logic              nstart_q, nstart_d;
    logic              nreset_q, nreset_d;
    logic              heater_q, heater_d;
    logic              ready_q, ready_d;
    logic              fail_q, fail_d;

    logic              timeout_c;
    logic              min_done_c;
    logic              stable_done_c;

    // Threshold qualifiers, all on the ELAPSED value sampled this edge
    assign timeout_c     = TIMER_OVFL || (TIMER_ELAPSED >= MAX_WARMUP);
    assign min_done_c    = TIMER_ELAPSED >= MIN_WARMUP;
    assign stable_done_c = TIME_W'(TIMER_ELAPSED - snap_q) >= STABLE_TIME;

    // Next state and next registered outputs; abort beats timeout beats qualification
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        nstart_d = 1'b1;
        nreset_d = 1'b1;
        heater_d = 1'b0;
        ready_d  = 1'b0;
        fail_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (WARMUP_REQ) state_d = ST_ARM;
            end
            ST_ARM: begin
                state_d = ST_HEAT;
            end
            ST_HEAT: begin
                if (!WARMUP_REQ) begin
                    state_d = ST_IDLE;
                end else if (timeout_c) begin
                    state_d = ST_FAIL;
                end else if (min_done_c && TEMP_OK) begin
                    state_d = ST_STABLE;
                    snap_d  = TIMER_ELAPSED;
                end
            end
            ST_STABLE: begin
                if (!WARMUP_REQ) begin
                    state_d = ST_IDLE;
                end else if (timeout_c) begin
                    state_d = ST_FAIL;
                end else if (!TEMP_OK) begin
                    state_d = ST_HEAT;
                end else if (stable_done_c) begin
                    state_d = ST_READY;
                end
            end
            ST_READY, ST_FAIL: begin
                if (!WARMUP_REQ) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moore decode of the state being entered
        case (state_d)
            ST_IDLE:   nreset_d = 1'b0;
            ST_ARM:    nstart_d = 1'b0;
            ST_HEAT,
            ST_STABLE: heater_d = 1'b1;
            ST_READY: begin
                heater_d = 1'b1;
                ready_d  = 1'b1;
            end
            ST_FAIL:   fail_d   = 1'b1;
            default:   nreset_d = 1'b0;
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            snap_q   <= '0;
            nstart_q <= 1'b1;
            nreset_q <= 1'b0;
            heater_q <= 1'b0;
            ready_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            nstart_q <= nstart_d;
            nreset_q <= nreset_d;
            heater_q <= heater_d;
            ready_q  <= ready_d;
            fail_q   <= fail_d;
        end
    end

    assign TIMER_nSTART = nstart_q;
    assign TIMER_nRESET = nreset_q;
    assign HEATER_EN    = heater_q;
    assign BUBBLE_READY = ready_q;
    assign WARMUP_FAIL  = fail_q;
    assign STATE        = state_q;

endmodule

// File: tb/tb_warmup_sequencer.sv
// Bench for warmup_sequencer: behavioural seconds counter, a cycle scoreboard
// fed by an independent reference of the sequencing rules, and scenario tasks.
module tb_warmup_sequencer;

    localparam logic [15:0] MIN_W  = 16'd3;
    localparam logic [15:0] MAX_W  = 16'd20;
    localparam logic [15:0] STAB_W = 16'd2;
    localparam int          PRESC  = 8;

    logic        MCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        WARMUP_REQ = 1'b0;
    logic        TEMP_OK = 1'b0;
    logic        TIMER_nSTART, TIMER_nRESET;
    logic [15:0] TIMER_ELAPSED;
    logic        TIMER_OVFL;
    logic        HEATER_EN, BUBBLE_READY, WARMUP_FAIL;
    logic [2:0]  STATE;

    logic        ovr = 1'b0;
    logic [15:0] ovr_el = 16'd0;
    logic        ovr_ovfl = 1'b0;

    logic        run_q = 1'b0;
    int          pre_q = 0;
    logic [15:0] cnt_q = 16'd0;
    logic        ovf_q = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    logic [2:0]  m_state = 3'd0;
    logic [15:0] m_snap = 16'd0;

    warmup_sequencer #(
        .MIN_WARMUP (MIN_W),
        .MAX_WARMUP (MAX_W),
        .STABLE_TIME(STAB_W)
    ) dut (
        .MCLK         (MCLK),
        .RESET        (RESET),
        .WARMUP_REQ   (WARMUP_REQ),
        .TEMP_OK      (TEMP_OK),
        .TIMER_nSTART (TIMER_nSTART),
        .TIMER_nRESET (TIMER_nRESET),
        .TIMER_ELAPSED(TIMER_ELAPSED),
        .TIMER_OVFL   (TIMER_OVFL),
        .HEATER_EN    (HEATER_EN),
        .BUBBLE_READY (BUBBLE_READY),
        .WARMUP_FAIL  (WARMUP_FAIL),
        .STATE        (STATE)
    );

    always #5 MCLK = ~MCLK;

    assign TIMER_ELAPSED = ovr ? ovr_el : cnt_q;
    assign TIMER_OVFL    = ovr ? ovr_ovfl : ovf_q;

    // Seconds counter: held clear by nRESET, started by nSTART, PRESC clocks per second
    always @(posedge MCLK) begin
        if (!TIMER_nRESET) begin
            run_q <= 1'b0;
            pre_q <= 0;
            cnt_q <= 16'd0;
            ovf_q <= 1'b0;
        end else begin
            if (!TIMER_nSTART) run_q <= 1'b1;
            if (run_q) begin
                if (pre_q == PRESC - 1) begin
                    pre_q <= 0;
                    if (cnt_q == 16'hFFFF) ovf_q <= 1'b1;
                    else cnt_q <= cnt_q + 16'd1;
                end else begin
                    pre_q <= pre_q + 1;
                end
            end
        end
    end

    // {STATE, nSTART, nRESET, HEATER_EN, BUBBLE_READY, WARMUP_FAIL}
    function automatic logic [7:0] expect_outs(input logic [2:0] s);
        case (s)
            3'd1:    return {s, 5'b01000};
            3'd2:    return {s, 5'b11100};
            3'd3:    return {s, 5'b11100};
            3'd4:    return {s, 5'b11110};
            3'd5:    return {s, 5'b11001};
            default: return {3'd0, 5'b10000};
        endcase
    endfunction

    // Reference sequencer: pushes the expected post-edge outputs at each edge
    always @(posedge MCLK) begin
        logic [2:0]  ns;
        logic [15:0] nsnap;
        logic        tmo;
        ns    = m_state;
        nsnap = m_snap;
        tmo   = TIMER_OVFL || (TIMER_ELAPSED >= MAX_W);
        if (RESET) begin
            ns    = 3'd0;
            nsnap = 16'd0;
        end else begin
            case (m_state)
                3'd0: if (WARMUP_REQ) ns = 3'd1;
                3'd1: ns = 3'd2;
                3'd2: begin
                    if (!WARMUP_REQ) ns = 3'd0;
                    else if (tmo) ns = 3'd5;
                    else if (TEMP_OK && TIMER_ELAPSED >= MIN_W) begin
                        ns    = 3'd3;
                        nsnap = TIMER_ELAPSED;
                    end
                end
                3'd3: begin
                    if (!WARMUP_REQ) ns = 3'd0;
                    else if (tmo) ns = 3'd5;
                    else if (!TEMP_OK) ns = 3'd2;
                    else if (TIMER_ELAPSED >= m_snap + STAB_W) ns = 3'd4;
                end
                3'd4, 3'd5: if (!WARMUP_REQ) ns = 3'd0;
                default: ns = 3'd0;
            endcase
        end
        m_state <= ns;
        m_snap  <= nsnap;
        exp_q.push_back(expect_outs(ns));
    end

    // Scoreboard drain and counter-protocol check, away from the active edge
    always @(negedge MCLK) begin
        logic [7:0] exp_v;
        logic [7:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {STATE, TIMER_nSTART, TIMER_nRESET, HEATER_EN, BUBBLE_READY, WARMUP_FAIL};
            n_chk++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL scoreboard t=%0t: outputs=%b expected=%b", $time, act_v, exp_v);
            end
            n_chk++;
            if (!TIMER_nSTART && !TIMER_nRESET) begin
                n_err++;
                $display("FAIL strobe_overlap t=%0t: nSTART and nRESET both low", $time);
            end
        end
    end

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (STATE === s) break;
            @(negedge MCLK);
        end
    endtask

    task automatic wait_cnt(input logic [15:0] v, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cnt_q === v) break;
            @(negedge MCLK);
        end
    endtask

    task automatic go_idle();
        WARMUP_REQ = 1'b0;
        TEMP_OK    = 1'b0;
        repeat (3) @(negedge MCLK);
    endtask

    task automatic test_reset();
        RESET      = 1'b1;
        WARMUP_REQ = 1'b1;
        repeat (3) @(negedge MCLK);
        n_chk++;
        if ({STATE, TIMER_nSTART, TIMER_nRESET, HEATER_EN, BUBBLE_READY, WARMUP_FAIL} !== 8'b000_10000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b%b%b%b%b%b required 000 1 0 0 0 0",
                     STATE, TIMER_nSTART, TIMER_nRESET, HEATER_EN, BUBBLE_READY, WARMUP_FAIL);
        end
        n_chk++;
        if (dut.snap_q !== 16'd0) begin
            n_err++;
            $display("FAIL reset_snap: got %0d required 0", dut.snap_q);
        end
        WARMUP_REQ = 1'b0;
        RESET      = 1'b0;
        @(negedge MCLK);
    endtask

    task automatic test_nominal();
        TEMP_OK    = 1'b1;
        WARMUP_REQ = 1'b1;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd1 || TIMER_nSTART !== 1'b0 || TIMER_nRESET !== 1'b1) begin
            n_err++;
            $display("FAIL nominal_arm: state=%0d nSTART=%b nRESET=%b required 1 0 1",
                     STATE, TIMER_nSTART, TIMER_nRESET);
        end
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd2 || HEATER_EN !== 1'b1) begin
            n_err++;
            $display("FAIL nominal_heat: state=%0d heater=%b required 2 1", STATE, HEATER_EN);
        end
        wait_state(3'd3, 60);
        n_chk++;
        if (STATE !== 3'd3 || cnt_q !== MIN_W || dut.snap_q !== MIN_W) begin
            n_err++;
            $display("FAIL nominal_stable_entry: state=%0d elapsed=%0d snap=%0d required 3 3 3",
                     STATE, cnt_q, dut.snap_q);
        end
        wait_state(3'd4, 60);
        n_chk++;
        if (STATE !== 3'd4 || BUBBLE_READY !== 1'b1 || cnt_q !== 16'd5) begin
            n_err++;
            $display("FAIL nominal_ready: state=%0d ready=%b elapsed=%0d required 4 1 5",
                     STATE, BUBBLE_READY, cnt_q);
        end
        WARMUP_REQ = 1'b0;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd0 || TIMER_nRESET !== 1'b0) begin
            n_err++;
            $display("FAIL nominal_release: state=%0d nRESET=%b required 0 0", STATE, TIMER_nRESET);
        end
        go_idle();
    endtask

    task automatic test_glitch();
        TEMP_OK    = 1'b1;
        WARMUP_REQ = 1'b1;
        wait_state(3'd3, 60);
        wait_cnt(16'd4, 20);
        TEMP_OK = 1'b0;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd2) begin
            n_err++;
            $display("FAIL glitch_drop: state=%0d required 2", STATE);
        end
        wait_cnt(16'd6, 40);
        TEMP_OK = 1'b1;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd3 || dut.snap_q !== 16'd6) begin
            n_err++;
            $display("FAIL glitch_resnap: state=%0d snap=%0d required 3 6", STATE, dut.snap_q);
        end
        wait_state(3'd4, 40);
        n_chk++;
        if (STATE !== 3'd4 || cnt_q !== 16'd8) begin
            n_err++;
            $display("FAIL glitch_ready: state=%0d elapsed=%0d required 4 8", STATE, cnt_q);
        end
        go_idle();
    endtask

    task automatic test_timeout();
        TEMP_OK    = 1'b0;
        WARMUP_REQ = 1'b1;
        wait_state(3'd5, 300);
        n_chk++;
        if (STATE !== 3'd5 || cnt_q !== MAX_W || HEATER_EN !== 1'b0 || WARMUP_FAIL !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_fail: state=%0d elapsed=%0d heater=%b fail=%b required 5 20 0 1",
                     STATE, cnt_q, HEATER_EN, WARMUP_FAIL);
        end
        WARMUP_REQ = 1'b0;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd0 || TIMER_nRESET !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_release: state=%0d nRESET=%b required 0 0", STATE, TIMER_nRESET);
        end
        go_idle();
    endtask

    task automatic test_priority();
        ovr        = 1'b1;
        ovr_el     = 16'd0;
        ovr_ovfl   = 1'b0;
        TEMP_OK    = 1'b1;
        WARMUP_REQ = 1'b1;
        wait_state(3'd2, 5);
        ovr_el = 16'd18;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd3 || dut.snap_q !== 16'd18) begin
            n_err++;
            $display("FAIL prio_stable: state=%0d snap=%0d required 3 18", STATE, dut.snap_q);
        end
        ovr_el = MAX_W;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd5) begin
            n_err++;
            $display("FAIL prio_timeout_over_ready: state=%0d required 5", STATE);
        end
        go_idle();
        ovr_el     = 16'd0;
        WARMUP_REQ = 1'b1;
        wait_state(3'd2, 5);
        ovr_el     = MAX_W;
        WARMUP_REQ = 1'b0;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd0) begin
            n_err++;
            $display("FAIL prio_abort_over_timeout: state=%0d required 0", STATE);
        end
        go_idle();
        ovr_el     = 16'd1;
        WARMUP_REQ = 1'b1;
        wait_state(3'd2, 5);
        ovr_ovfl = 1'b1;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd5 || WARMUP_FAIL !== 1'b1) begin
            n_err++;
            $display("FAIL prio_ovfl: state=%0d fail=%b required 5 1", STATE, WARMUP_FAIL);
        end
        go_idle();
        ovr      = 1'b0;
        ovr_ovfl = 1'b0;
        ovr_el   = 16'd0;
    endtask

    task automatic test_reset_abort();
        logic cleared;
        TEMP_OK    = 1'b1;
        WARMUP_REQ = 1'b1;
        wait_state(3'd4, 80);
        RESET = 1'b1;
        @(negedge MCLK);
        RESET = 1'b0;
        n_chk++;
        if ({STATE, TIMER_nSTART, TIMER_nRESET, HEATER_EN, BUBBLE_READY, WARMUP_FAIL} !== 8'b000_10000) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b%b%b%b%b%b required 000 1 0 0 0 0",
                     STATE, TIMER_nSTART, TIMER_nRESET, HEATER_EN, BUBBLE_READY, WARMUP_FAIL);
        end
        TEMP_OK = 1'b0;
        wait_state(3'd2, 5);
        wait_cnt(16'd1, 20);
        WARMUP_REQ = 1'b0;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd0 || TIMER_nRESET !== 1'b0 || HEATER_EN !== 1'b0) begin
            n_err++;
            $display("FAIL abort_heat: state=%0d nRESET=%b heater=%b required 0 0 0",
                     STATE, TIMER_nRESET, HEATER_EN);
        end
        cleared = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (cnt_q === 16'd0) cleared = 1'b1;
            if (!cleared) @(negedge MCLK);
        end
        if (cnt_q === 16'd0) cleared = 1'b1;
        n_chk++;
        if (!cleared) begin
            n_err++;
            $display("FAIL abort_clear: elapsed=%0d required 0 within 2 edges", cnt_q);
        end
        WARMUP_REQ = 1'b1;
        @(negedge MCLK);
        n_chk++;
        if (STATE !== 3'd1 || TIMER_nSTART !== 1'b0) begin
            n_err++;
            $display("FAIL rearm: state=%0d nSTART=%b required 1 0", STATE, TIMER_nSTART);
        end
        go_idle();
    endtask

    initial begin
        @(negedge MCLK);
        test_reset();
        test_nominal();
        test_glitch();
        test_timeout();
        test_priority();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
